pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Per-frame game sequencer for the Pong display. It converts two ADC paddle samples into
//  paddle Y positions and moves the ball. It detects wall and paddle bounces, keeps the
//  score and runs the serve, play and game-over flow.
//  Its outputs drive the pongbar1_y/pongbar2_y/bal_x/bal_y inputs of the VGA pattern
//  generator. They change only on frame_tick, a vblank pulse, so a frame never tears.
// PARAMETERS
//  H_ACTIVE     640  visible pixels per line
//  V_ACTIVE     480  visible lines per frame
//  BAR_W        10   paddle width; left paddle x 0..BAR_W-1, right H_ACTIVE-BAR_W..H_ACTIVE-1
//  BAR_H        40   paddle height in lines
//  BALL_SPEED   2    ball step per frame on each axis, in pixels
//  SERVE_FRAMES 60   frames the ball rests at centre before play
//  WIN_SCORE    9    score that ends the game
// PORTS
//  clk         in   1   pixel clock
//  reset_n     in   1   reset, asynchronous, active-low
//  frame_tick  in   1   one-cycle pulse, once per frame at vblank start
//  adc1_val    in   12  paddle 1 ADC sample
//  adc1_valid  in   1   one-cycle strobe, adc1_val is valid
//  adc2_val    in   12  paddle 2 ADC sample
//  adc2_valid  in   1   one-cycle strobe, adc2_val is valid
//  start_btn   in   1   start button level, already synchronised; rising edge is detected internally
//  pongbar1_y  out  16  left paddle top line
//  pongbar2_y  out  16  right paddle top line
//  bal_x       out  16  ball x position
//  bal_y       out  16  ball y position
//  score1      out  4   left player score
//  score2      out  4   right player score
//  game_state  out  3   current FSM state encoding
// BEHAVIOUR
//  Reset values:
//   pongbar1_y = pongbar2_y = (V_ACTIVE-BAR_H)/2 = 220
//   bal_x = H_ACTIVE/2 = 320; bal_y = V_ACTIVE/2 = 240
//   scores 0; state IDLE; dx = +1 (right); dy = +1 (down); sample registers 0
//  Samples: adcN_valid loads sampN <= adcN_val. Values are held between strobes.
//  Paddles: on each frame_tick in any state, pongbarN_y <= min(sampN>>3, V_ACTIVE-BAR_H).
//   The clamp gives a range of 0..440.
//   If adcN_valid and frame_tick coincide, the new adcN_val is used (bypass).
//  Latency: every output register updates on the clk edge after the frame_tick cycle.
//  Ball and score logic run only on frame_tick, except IDLE/GAMEOVER start edges.
//  FSM (encoding 0..4):
//   IDLE:     ball held at centre. start edge -> SERVE, frame counter cleared.
//   SERVE:    ball forced to centre. Counts frame_ticks.
//             After SERVE_FRAMES ticks -> PLAY. dy = +1; dx is kept.
//   PLAY:     per tick, nx = bal_x + dx*BALL_SPEED and ny = bal_y + dy*BALL_SPEED.
//             Computed signed, 13 bits.
//   POINT:    lasts exactly one frame_tick.
//             Scorer's score = WIN_SCORE -> GAMEOVER; otherwise -> SERVE.
//   GAMEOVER: ball at centre, scores frozen.
//             start edge -> scores cleared, dx = +1 -> SERVE.
//  PLAY vertical rule:
//   ny <= 0 -> bal_y = 0, dy = +1.
//   ny >= V_ACTIVE-1 -> bal_y = V_ACTIVE-1, dy = -1.
//  PLAY left-side rule, when dx = -1 and nx < BAR_W:
//   If pongbar1_y <= bal_y < pongbar1_y+BAR_H: bounce, bal_x = BAR_W, dx = +1.
//   Otherwise score2 += 1, dx = -1 (next serve goes toward the loser) -> POINT.
//  PLAY right-side rule: mirror of the left side.
//   Threshold: nx > H_ACTIVE-BAR_W-1.
//   Bounce: bal_x = H_ACTIVE-BAR_W-1, dx = -1.
//   Miss: score1 += 1, dx = +1 -> POINT.
//  Paddle test timing: the hit test uses bal_y (pre-move) and the pongbar values
//   registered before this tick.
//  Corner case: the vertical and horizontal rules both apply in the same tick.
//  Score range: scores saturate at WIN_SCORE and never wrap.
//  start_btn edge in SERVE/PLAY/POINT: ignored.
//   The edge detector still updates, so a held button does not retrigger.
//  Reset mid-game: all registers return to their reset values immediately (asynchronous).
// TESTING
//  T1 reset, adc1 = 4095, adc2 = 0, one tick -> pongbar1_y = 440, pongbar2_y = 0
//     (clamp, and outputs are 220 until the tick)
//  T2 start, 60 ticks -> state PLAY; next tick -> bal_x = 322, bal_y = 242
//  T3 ball near bottom: bal_y = 478, dy = +1 -> after tick bal_y = 479, dy = -1;
//     next tick bal_y = 477
//  T4 paddle 1 at 220, ball moving left at x = 11, y = 230 -> tick gives bal_x = 10,
//     dx = +1, score unchanged
//  T5 paddle 1 at 0, ball moving left at x = 11, y = 300 -> score2 = 1, POINT, then SERVE;
//     ball at 320,240, dx = -1
//  T6 score1 = 8, right-side miss -> score1 = 9, GAMEOVER; further ticks do not change
//     the ball or scores; start edge -> scores 0, SERVE

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong sequencer: paddle positions from ADC samples, ball motion, bounces,
// scoring and the serve/play/game-over flow. Outputs only move on frame_tick.
module pong_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BAR_W        = 10,
  parameter int BAR_H        = 40,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_frame_tick,
  input  logic [11:0] i_adc1_val,
  input  logic        i_adc1_valid,
  input  logic [11:0] i_adc2_val,
  input  logic        i_adc2_valid,
  input  logic        i_start_btn,
  output logic [15:0] o_pongbar1_y,
  output logic [15:0] o_pongbar2_y,
  output logic [15:0] o_bal_x,
  output logic [15:0] o_bal_y,
  output logic [3:0]  o_score1,
  output logic [3:0]  o_score2,
  output logic [2:0]  o_game_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SERVE    = 3'd1;
  localparam logic [2:0] S_PLAY     = 3'd2;
  localparam logic [2:0] S_POINT    = 3'd3;
  localparam logic [2:0] S_GAMEOVER = 3'd4;

  localparam int               CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  localparam logic [9:0]  PAD_MAX   = 10'(V_ACTIVE - BAR_H);
  localparam logic [11:0] SAMP_CLIP = 12'((V_ACTIVE - BAR_H) * 8);
  localparam logic [9:0]  BAR_H_V   = 10'(BAR_H);
  localparam logic [9:0]  X_CTR     = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_CTR     = 10'(V_ACTIVE / 2);
  localparam logic [9:0]  X_LEFT    = 10'(BAR_W);
  localparam logic [9:0]  X_RIGHT   = 10'(H_ACTIVE - BAR_W - 1);
  localparam logic [9:0]  Y_MAX     = 10'(V_ACTIVE - 1);
  localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

  localparam logic signed [12:0] STEP     = 13'(BALL_SPEED);
  localparam logic signed [12:0] NX_LEFT  = 13'(BAR_W);
  localparam logic signed [12:0] NX_RIGHT = 13'(H_ACTIVE - BAR_W - 1);
  localparam logic signed [12:0] NY_MAX   = 13'(V_ACTIVE - 1);

  logic [11:0]      r_samp1, r_samp2;
  logic [9:0]       r_pad1, r_pad2;
  logic [9:0]       r_bal_x, r_bal_y;
  logic             r_dx, r_dy;
  logic [3:0]       r_score1, r_score2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_start_d;

  logic [11:0]      w_src1, w_src2;
  logic [9:0]       w_pad1_n, w_pad2_n;
  logic             w_edge, w_hit1, w_hit2;
  logic signed [12:0] w_nx, w_ny;
  logic [9:0]       w_bal_x_n, w_bal_y_n;
  logic             w_dx_n, w_dy_n;
  logic [3:0]       w_score1_n, w_score2_n;
  logic [2:0]       w_state_n;
  logic [CNT_W-1:0] w_cnt_n;

  // A strobe arriving on the tick cycle bypasses the held sample.
  assign w_src1   = i_adc1_valid ? i_adc1_val : r_samp1;
  assign w_src2   = i_adc2_valid ? i_adc2_val : r_samp2;
  assign w_pad1_n = (w_src1 >= SAMP_CLIP) ? PAD_MAX : {1'b0, w_src1[11:3]};
  assign w_pad2_n = (w_src2 >= SAMP_CLIP) ? PAD_MAX : {1'b0, w_src2[11:3]};

  assign w_edge = i_start_btn & ~r_start_d;

  // Hit test uses the pre-move ball row against the paddles registered before this tick.
  assign w_hit1 = (r_bal_y >= r_pad1) && (r_bal_y < r_pad1 + BAR_H_V);
  assign w_hit2 = (r_bal_y >= r_pad2) && (r_bal_y < r_pad2 + BAR_H_V);

  assign w_nx = r_dx ? ($signed({3'b000, r_bal_x}) + STEP) : ($signed({3'b000, r_bal_x}) - STEP);
  assign w_ny = r_dy ? ($signed({3'b000, r_bal_y}) + STEP) : ($signed({3'b000, r_bal_y}) - STEP);

  always_comb begin
    w_bal_x_n  = r_bal_x;
    w_bal_y_n  = r_bal_y;
    w_dx_n     = r_dx;
    w_dy_n     = r_dy;
    w_score1_n = r_score1;
    w_score2_n = r_score2;
    w_state_n  = r_state;
    w_cnt_n    = r_frame_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_n = S_SERVE;
          w_cnt_n   = '0;
        end
      end
      S_SERVE: begin
        if (i_frame_tick) begin
          w_bal_x_n = X_CTR;
          w_bal_y_n = Y_CTR;
          if (r_frame_cnt == CNT_LAST) begin
            w_state_n = S_PLAY;
            w_dy_n    = 1'b1;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_frame_cnt + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (i_frame_tick) begin
          if (w_ny <= 13'sd0) begin
            w_bal_y_n = '0;
            w_dy_n    = 1'b1;
          end else if (w_ny >= NY_MAX) begin
            w_bal_y_n = Y_MAX;
            w_dy_n    = 1'b0;
          end else begin
            w_bal_y_n = w_ny[9:0];
          end
          w_bal_x_n = w_nx[9:0];
          // On a miss the ball keeps its overshoot position until POINT recentres it.
          if (!r_dx && (w_nx < NX_LEFT)) begin
            if (w_hit1) begin
              w_bal_x_n = X_LEFT;
              w_dx_n    = 1'b1;
            end else begin
              if (r_score2 < WIN) w_score2_n = r_score2 + 1'b1;
              w_dx_n    = 1'b0;
              w_state_n = S_POINT;
            end
          end else if (r_dx && (w_nx > NX_RIGHT)) begin
            if (w_hit2) begin
              w_bal_x_n = X_RIGHT;
              w_dx_n    = 1'b0;
            end else begin
              if (r_score1 < WIN) w_score1_n = r_score1 + 1'b1;
              w_dx_n    = 1'b1;
              w_state_n = S_POINT;
            end
          end
        end
      end
      S_POINT: begin
        // dx already points at the loser, so it also identifies the scorer.
        if (i_frame_tick) begin
          w_bal_x_n = X_CTR;
          w_bal_y_n = Y_CTR;
          w_cnt_n   = '0;
          w_state_n = ((r_dx ? r_score1 : r_score2) == WIN) ? S_GAMEOVER : S_SERVE;
        end
      end
      S_GAMEOVER: begin
        if (w_edge) begin
          w_score1_n = '0;
          w_score2_n = '0;
          w_dx_n     = 1'b1;
          w_state_n  = S_SERVE;
          w_cnt_n    = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_samp1     <= '0;
      r_samp2     <= '0;
      r_pad1      <= PAD_MAX >> 1;
      r_pad2      <= PAD_MAX >> 1;
      r_bal_x     <= X_CTR;
      r_bal_y     <= Y_CTR;
      r_dx        <= 1'b1;
      r_dy        <= 1'b1;
      r_score1    <= '0;
      r_score2    <= '0;
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_start_d   <= 1'b0;
    end else begin
      r_start_d <= i_start_btn;
      if (i_adc1_valid) r_samp1 <= i_adc1_val;
      if (i_adc2_valid) r_samp2 <= i_adc2_val;
      if (i_frame_tick) begin
        r_pad1 <= w_pad1_n;
        r_pad2 <= w_pad2_n;
      end
      r_bal_x     <= w_bal_x_n;
      r_bal_y     <= w_bal_y_n;
      r_dx        <= w_dx_n;
      r_dy        <= w_dy_n;
      r_score1    <= w_score1_n;
      r_score2    <= w_score2_n;
      r_state     <= w_state_n;
      r_frame_cnt <= w_cnt_n;
    end
  end

  assign o_pongbar1_y = {6'b0, r_pad1};
  assign o_pongbar2_y = {6'b0, r_pad2};
  assign o_bal_x      = {6'b0, r_bal_x};
  assign o_bal_y      = {6'b0, r_bal_y};
  assign o_score1     = r_score1;
  assign o_score2     = r_score2;
  assign o_game_state = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed start-up steps, then randomized play checked
// every cycle against a frame-level game model.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frameTick;
  logic [11:0] adc1Val, adc2Val;
  logic        adc1Valid, adc2Valid;
  logic        startBtn;
  logic [15:0] pongbar1Y, pongbar2Y, balX, balY;
  logic [3:0]  score1, score2;
  logic [2:0]  gameState;

  int assertCount = 0;
  int failCount   = 0;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_GAMEOVER = 4;

  int mState, mCnt, mBalX, mBalY, mDx, mDy, mS1, mS2, mPad1, mPad2, mSamp1, mSamp2;
  bit mPrevBtn;
  bit tbBtn;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_frame_tick (frameTick),
    .i_adc1_val   (adc1Val),
    .i_adc1_valid (adc1Valid),
    .i_adc2_val   (adc2Val),
    .i_adc2_valid (adc2Valid),
    .i_start_btn  (startBtn),
    .o_pongbar1_y (pongbar1Y),
    .o_pongbar2_y (pongbar2Y),
    .o_bal_x      (balX),
    .o_bal_y      (balY),
    .o_score1     (score1),
    .o_score2     (score2),
    .o_game_state (gameState)
  );

  task automatic modelReset();
    mState = M_IDLE; mCnt = 0; mBalX = 320; mBalY = 240; mDx = 1; mDy = 1;
    mS1 = 0; mS2 = 0; mPad1 = 220; mPad2 = 220; mSamp1 = 0; mSamp2 = 0; mPrevBtn = 0;
  endtask

  function automatic int clampPad(input int sample);
    return (sample / 8 > 440) ? 440 : sample / 8;
  endfunction

  // One clock edge of the game as described by its rules, in plain integer terms.
  task automatic modelStep(input bit tick, input bit v1, input int a1, input bit v2,
                           input int a2, input bit btn);
    int src1, src2, nx, ny, oldY, scorer;
    bit edgeSeen;
    edgeSeen = btn && !mPrevBtn;
    mPrevBtn = btn;
    src1 = v1 ? a1 : mSamp1;
    src2 = v2 ? a2 : mSamp2;
    if (v1) mSamp1 = a1;
    if (v2) mSamp2 = a2;
    case (mState)
      M_IDLE: if (edgeSeen) begin mState = M_SERVE; mCnt = 0; end
      M_SERVE: if (tick) begin
        mBalX = 320; mBalY = 240; mCnt++;
        if (mCnt == 60) begin mState = M_PLAY; mDy = 1; end
      end
      M_PLAY: if (tick) begin
        oldY = mBalY;
        nx = mBalX + 2 * mDx;
        ny = mBalY + 2 * mDy;
        if (ny <= 0) begin mBalY = 0; mDy = 1; end
        else if (ny >= 479) begin mBalY = 479; mDy = -1; end
        else mBalY = ny;
        mBalX = nx;
        if (mDx < 0 && nx < 10) begin
          if (oldY >= mPad1 && oldY < mPad1 + 40) begin mBalX = 10; mDx = 1; end
          else begin mS2 = (mS2 < 9) ? mS2 + 1 : 9; mDx = -1; mState = M_POINT; end
        end else if (mDx > 0 && nx > 629) begin
          if (oldY >= mPad2 && oldY < mPad2 + 40) begin mBalX = 629; mDx = -1; end
          else begin mS1 = (mS1 < 9) ? mS1 + 1 : 9; mDx = 1; mState = M_POINT; end
        end
      end
      M_POINT: if (tick) begin
        scorer = (mDx > 0) ? mS1 : mS2;
        mBalX = 320; mBalY = 240; mCnt = 0;
        mState = (scorer == 9) ? M_GAMEOVER : M_SERVE;
      end
      M_GAMEOVER: if (edgeSeen) begin
        mS1 = 0; mS2 = 0; mDx = 1; mState = M_SERVE; mCnt = 0;
      end
      default: mState = M_IDLE;
    endcase
    if (tick) begin
      mPad1 = clampPad(src1);
      mPad2 = clampPad(src2);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] observed, input int expected);
    logic [15:0] exp16;
    exp16 = 16'(expected);
    assertCount++;
    assert (observed === exp16) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, exp16);
    end
  endtask

  task automatic checkOutput();
    checkValue("pongbar1_y", pongbar1Y, mPad1);
    checkValue("pongbar2_y", pongbar2Y, mPad2);
    checkValue("bal_x", balX, mBalX);
    checkValue("bal_y", balY, mBalY);
    checkValue("score1", {12'b0, score1}, mS1);
    checkValue("score2", {12'b0, score2}, mS2);
    checkValue("game_state", {13'b0, gameState}, mState);
  endtask

  task automatic applyStimulus(input bit tick, input bit v1, input int a1, input bit v2,
                               input int a2, input bit btn);
    frameTick = tick; adc1Valid = v1; adc1Val = 12'(a1);
    adc2Valid = v2; adc2Val = 12'(a2); startBtn = btn;
    @(posedge clk);
    modelStep(tick, v1, a1, v2, a2, btn);
    #1;
    checkOutput();
  endtask

  // mode 0: track ball, 1: track with occasional random jumps, 2: stay away from ball
  function automatic int pickAdc(input int mode);
    int pad;
    pad = mBalY - 20;
    if (pad < 0) pad = 0;
    if (pad > 440) pad = 440;
    if (mode == 2) return (mBalY < 240) ? 4095 : int'($urandom_range(0, 7));
    if (mode == 1 && $urandom_range(0, 3) == 0) return int'($urandom_range(0, 4095));
    return pad * 8 + int'($urandom_range(0, 7));
  endfunction

  task automatic runFrame(input int mode1, input int mode2, input bit btnRandom, input bit forceStrobe);
    for (int c = 0; c < 2; c++) begin
      if (btnRandom && $urandom_range(0, 31) == 0) tbBtn = !tbBtn;
      applyStimulus(0, 1'($urandom_range(0, 1)), pickAdc(mode1),
                       1'($urandom_range(0, 1)), pickAdc(mode2), tbBtn);
    end
    applyStimulus(1, forceStrobe | 1'($urandom_range(0, 1)), pickAdc(mode1),
                     forceStrobe | 1'($urandom_range(0, 1)), pickAdc(mode2), tbBtn);
  endtask

  initial begin
    reset_n = 1'b0; frameTick = 0; adc1Val = 0; adc1Valid = 0;
    adc2Val = 0; adc2Valid = 0; startBtn = 0; tbBtn = 0;
    modelReset();
    #12;
    checkOutput();
    checkValue("reset_pad1", pongbar1Y, 220);
    checkValue("reset_bal_x", balX, 320);
    checkValue("reset_bal_y", balY, 240);
    @(negedge clk) reset_n = 1'b1;

    // Samples alone must not move the paddles; the next tick applies them with clamping.
    applyStimulus(0, 1, 4095, 1, 0, 0);
    checkValue("t1_pad1_before_tick", pongbar1Y, 220);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkValue("t1_pad1_clamped", pongbar1Y, 440);
    checkValue("t1_pad2_zero", pongbar2Y, 0);

    applyStimulus(0, 0, 0, 0, 0, 1);
    checkValue("t2_serve", {13'b0, gameState}, 1);
    for (int f = 0; f < 60; f++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
    end
    checkValue("t2_play", {13'b0, gameState}, 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkValue("t2_first_move_x", balX, 322);
    checkValue("t2_first_move_y", balY, 242);

    tbBtn = 1;
    for (int f = 0; f < 600; f++) runFrame(1, 1, 1, 0);

    tbBtn = 0;
    for (int f = 0; f < 6000 && mState != M_GAMEOVER; f++) runFrame(0, 2, 0, 1);
    checkValue("gameover_reached", {13'b0, gameState}, 4);
    for (int f = 0; f < 5; f++) runFrame(1, 1, 0, 0);
    checkValue("gameover_held", {13'b0, gameState}, 4);

    applyStimulus(0, 0, 0, 0, 0, 1);
    checkValue("restart_serve", {13'b0, gameState}, 1);
    checkValue("restart_score1", {12'b0, score1}, 0);
    checkValue("restart_score2", {12'b0, score2}, 0);
    tbBtn = 1;
    for (int f = 0; f < 80; f++) runFrame(1, 1, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 modelReset();
    checkOutput();
    checkValue("async_reset_state", {13'b0, gameState}, 0);
    checkValue("async_reset_pad2", pongbar2Y, 220);
    @(negedge clk) reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
